reg_file_bypass: RTL and testbench

- Architectural register file for the processor's decode stage.
- Consumes the writeback value selected by the 2:1 writeback mux (ALU result vs. memory data) and supplies two source operands to the execute stage.
- Includes same-cycle write-to-read bypass, so an instruction in decode sees the value being written back in that same cycle without an extra stall.

---
 rtl/reg_file_bypass_if.sv | 33 +++
 rtl/reg_file_bypass.sv | 121 ++++++++++++
 tb/tb_reg_file_bypass.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_bypass_if.sv
// reg_file_bypass_if
//   Operand/writeback bundle between decode control and the register file.
//   master : decode/writeback control (drives selects, write data, strobe)
//   slave  : register file (returns both operands and the integrity flag)
//   Signals:
//     read1RegSel, read2RegSel  source register indices
//     writeRegSel               destination register index
//     writeData, writeEn        writeback value and strobe
//     read1Data, read2Data      operands (combinational from the slave)
//     err                       X/Z seen on a control input
interface reg_file_bypass_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0] read1RegSel;
  logic [SEL_W-1:0] read2RegSel;
  logic [SEL_W-1:0] writeRegSel;
  logic [WIDTH-1:0] writeData;
  logic             writeEn;
  logic [WIDTH-1:0] read1Data;
  logic [WIDTH-1:0] read2Data;
  logic             err;

  modport master (
    output read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    input  read1Data, read2Data, err
  );

  modport slave (
    input  read1RegSel, read2RegSel, writeRegSel, writeData, writeEn,
    output read1Data, read2Data, err
  );
endinterface

// File: rtl/reg_file_bypass.sv
// reg_file_bypass
//   Decode-stage architectural register file with same-cycle write-to-read
//   bypass. Built structurally from a dff cell, a 2:1 mux cell and an N:1
//   mux cell plus select comparators.
//   Ports:
//     clk  system clock, rising edge
//     rst  synchronous active-high reset (clears all registers)
//     rf   reg_file_bypass_if.slave (selects, write data/strobe, operands, err)

// Storage cell: synchronous clear, load on enable.
module rfb_dff #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst)       data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// 2:1 mux cell.
module rfb_mux2 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// N:1 mux cell.
module rfb_muxn #(
  parameter int W = 16,
  parameter int N = 8,
  parameter int S = 3
) (
  input  logic [W-1:0] d_i [N],
  input  logic [S-1:0] sel_i,
  output logic [W-1:0] y_o
);
  assign y_o = d_i[sel_i];
endmodule

module reg_file_bypass #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_bypass_if.slave  rf
);
  logic             wr_ok;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] rd1_raw;
  logic [WIDTH-1:0] rd2_raw;
  logic             byp1;
  logic             byp2;

  // Reset wins over a concurrent write and also disables bypass, so the
  // operands show stored values (zero after the first reset edge).
  assign wr_ok = rf.writeEn & ~rst;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic wr_hit;
    assign wr_hit = wr_ok & (rf.writeRegSel == SEL_W'(i));

    rfb_dff #(.W(WIDTH)) u_dff (
      .clk  (clk),
      .rst  (rst),
      .en_i (wr_hit),
      .d_i  (rf.writeData),
      .q_o  (regs_q[i])
    );
  end

  rfb_muxn #(.W(WIDTH), .N(NUM_REGS), .S(SEL_W)) u_rd1 (
    .d_i   (regs_q),
    .sel_i (rf.read1RegSel),
    .y_o   (rd1_raw)
  );

  rfb_muxn #(.W(WIDTH), .N(NUM_REGS), .S(SEL_W)) u_rd2 (
    .d_i   (regs_q),
    .sel_i (rf.read2RegSel),
    .y_o   (rd2_raw)
  );

  // Bypass forwards the in-flight writeback so decode needs no stall; the
  // value stored at the edge equals the forwarded one, keeping output steady.
  assign byp1 = wr_ok & (rf.writeRegSel == rf.read1RegSel);
  assign byp2 = wr_ok & (rf.writeRegSel == rf.read2RegSel);

  rfb_mux2 #(.W(WIDTH)) u_byp1 (
    .a_i   (rd1_raw),
    .b_i   (rf.writeData),
    .sel_i (byp1),
    .y_o   (rf.read1Data)
  );

  rfb_mux2 #(.W(WIDTH)) u_byp2 (
    .a_i   (rd2_raw),
    .b_i   (rf.writeData),
    .sel_i (byp2),
    .y_o   (rf.read2Data)
  );

  // Any X/Z bit on a control input poisons the reduction XOR.
  assign rf.err = ((^{rf.writeEn, rf.writeRegSel, rf.read1RegSel, rf.read2RegSel}) === 1'bx);
endmodule

// File: tb/tb_reg_file_bypass.sv
// tb_reg_file_bypass
//   Directed scenarios followed by randomized traffic, checked against an
//   array-based reference model of the register file.
module tb_reg_file_bypass;
  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int SEL_W = 3;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] model [NREG];

  reg_file_bypass_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  reg_file_bypass #(.WIDTH(WIDTH), .NUM_REGS(NREG), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Expected operand for a select under the current inputs.
  function automatic logic [WIDTH-1:0] exp_rd(input logic [SEL_W-1:0] sel);
    if (!rst && bus.writeEn === 1'b1 && bus.writeRegSel == sel) return bus.writeData;
    return model[sel];
  endfunction

  // Advance one edge and apply it to the model; land 1ns after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREG; i++) model[i] = '0;
    end else if (bus.writeEn === 1'b1) begin
      model[bus.writeRegSel] = bus.writeData;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, ".rd1"}, bus.read1Data, exp_rd(bus.read1RegSel));
    chk({tag, ".rd2"}, bus.read2Data, exp_rd(bus.read2RegSel));
    chk({tag, ".err"}, {15'b0, bus.err}, 16'h0000);
  endtask

  task automatic wr(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] data);
    bus.writeEn     = 1'b1;
    bus.writeRegSel = sel;
    bus.writeData   = data;
    step();
    bus.writeEn = 1'b0;
  endtask

  initial begin
    logic [SEL_W-1:0] xsel;
    logic             xen;
    logic             exp_err;

    rst             = 1'b1;
    bus.writeEn     = 1'b1;
    bus.writeData   = 16'hFFFF;
    bus.writeRegSel = 3'd3;
    bus.read1RegSel = 3'd3;
    bus.read2RegSel = 3'd0;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset held two cycles with a write pending.
    step();
    step();
    rst         = 1'b0;
    bus.writeEn = 1'b0;
    for (int s = 0; s < NREG; s++) begin
      bus.read1RegSel = SEL_W'(s);
      bus.read2RegSel = SEL_W'(NREG - 1 - s);
      #1;
      chk($sformatf("rst.rd1[%0d]", s), bus.read1Data, 16'h0000);
      chk($sformatf("rst.rd2[%0d]", NREG - 1 - s), bus.read2Data, 16'h0000);
    end
    chk("rst.err", {15'b0, bus.err}, 16'h0000);

    // Plain write then read.
    wr(3'd2, 16'h1234);
    wr(3'd7, 16'hBEEF);
    bus.read1RegSel = 3'd2;
    bus.read2RegSel = 3'd7;
    #1;
    chk("wr.r2", bus.read1Data, 16'h1234);
    chk("wr.r7", bus.read2Data, 16'hBEEF);
    for (int s = 0; s < NREG; s++) begin
      if (s != 2 && s != 7) begin
        bus.read1RegSel = SEL_W'(s);
        #1;
        chk($sformatf("wr.hold[%0d]", s), bus.read1Data, 16'h0000);
      end
    end

    // Dual-port bypass.
    wr(3'd5, 16'h0001);
    wr(3'd3, 16'h0003);
    wr(3'd4, 16'h4444);
    bus.writeEn     = 1'b1;
    bus.writeRegSel = 3'd5;
    bus.writeData   = 16'hA5A5;
    bus.read1RegSel = 3'd5;
    bus.read2RegSel = 3'd5;
    #1;
    chk("byp.pre1", bus.read1Data, 16'hA5A5);
    chk("byp.pre2", bus.read2Data, 16'hA5A5);
    step();
    bus.writeEn = 1'b0;
    #1;
    chk("byp.post1", bus.read1Data, 16'hA5A5);
    chk("byp.post2", bus.read2Data, 16'hA5A5);

    // No bypass on select mismatch or with the strobe low.
    bus.writeEn     = 1'b1;
    bus.writeRegSel = 3'd4;
    bus.writeData   = 16'h7777;
    bus.read1RegSel = 3'd3;
    #1;
    chk("nobyp.sel", bus.read1Data, 16'h0003);
    bus.writeEn     = 1'b0;
    bus.read2RegSel = 3'd4;
    #1;
    chk("nobyp.en", bus.read2Data, 16'h4444);
    step();
    #1;
    chk("nobyp.keep", bus.read2Data, 16'h4444);

    // Reset mid-operation discards the concurrent write.
    wr(3'd6, 16'h5555);
    rst             = 1'b1;
    bus.writeEn     = 1'b1;
    bus.writeRegSel = 3'd6;
    bus.writeData   = 16'h9999;
    bus.read1RegSel = 3'd6;
    #1;
    chk("rstmid.pre", bus.read1Data, 16'h5555);
    chk("rstmid.err", {15'b0, bus.err}, 16'h0000);
    step();
    #1;
    chk("rstmid.post", bus.read1Data, 16'h0000);
    rst         = 1'b0;
    bus.writeEn = 1'b0;

    // Unknown control inputs raise err and leave state alone.
    wr(3'd1, 16'h0B0B);
    xsel            = 3'b0x1;
    bus.read2RegSel = xsel;
    exp_err         = $isunknown(xsel);
    #1;
    chk("err.sel", {15'b0, bus.err}, {15'b0, exp_err});
    step();
    bus.read2RegSel = 3'd1;
    #1;
    chk("err.selclr", {15'b0, bus.err}, 16'h0000);
    chk("err.hold", bus.read2Data, 16'h0B0B);
    xen         = 1'bz;
    bus.writeEn = xen;
    exp_err     = $isunknown(xen);
    #1;
    chk("err.en", {15'b0, bus.err}, {15'b0, exp_err});
    bus.writeEn = 1'b0;
    #1;
    chk("err.enclr", {15'b0, bus.err}, 16'h0000);
    step();

    // Randomized traffic, biased toward select collisions.
    for (int n = 0; n < 400; n++) begin
      rst             = ($urandom_range(0, 24) == 0);
      bus.writeEn     = 1'($urandom);
      bus.writeRegSel = SEL_W'($urandom);
      bus.writeData   = WIDTH'($urandom);
      bus.read1RegSel = ($urandom_range(0, 2) == 0) ? bus.writeRegSel : SEL_W'($urandom);
      bus.read2RegSel = ($urandom_range(0, 2) == 0) ? bus.writeRegSel : SEL_W'($urandom);
      check_model($sformatf("rnd%0d", n));
      step();
      check_model($sformatf("rnd%0d.post", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
